// File: rtl/multi_digit_led_driver_pkg.sv
// Shared definitions for the multiplexed seven-segment LED driver:
// scan FSM states, active-low segment encodings and all-off constants.
package multi_digit_led_driver_pkg;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } state_t;

   // Segments are active-low, ordered {a,b,c,d,e,f,g}.
   localparam logic [6:0] SEG_OFF = 7'b1111111;
   localparam logic       DP_OFF  = 1'b1;

   localparam logic [6:0] SEG_CODES [16] = '{
      7'b0000001,   // 0
      7'b1001111,   // 1
      7'b0010010,   // 2
      7'b0000110,   // 3
      7'b1001100,   // 4
      7'b0100100,   // 5
      7'b0100000,   // 6
      7'b0001111,   // 7
      7'b0000000,   // 8
      7'b0000100,   // 9
      7'b0001000,   // A
      7'b1100000,   // b
      7'b0110001,   // C
      7'b1000010,   // d
      7'b0110000,   // E
      7'b0111000    // F
   };

endpackage

// File: rtl/multi_digit_led_driver_seg7_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decoder
   import multi_digit_led_driver_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   // Table lookup of the segment pattern for the nibble.
   always_comb begin
      o_seg = SEG_CODES[i_nibble];
   end

endmodule

// File: rtl/multi_digit_led_driver.sv
// Time-multiplexed seven-segment driver. Each digit gets an optional
// all-off blanking gap followed by a dwell period. New display content is
// staged in a shadow register and only committed at a frame boundary so a
// frame never shows a mix of old and new values.
module multi_digit_led_driver
   import multi_digit_led_driver_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int DWELL_CYCLES = 16,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   mask_in,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    pending,
   output logic                    frame_start
);

   localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int IDX_W   = $clog2(NUM_DIGITS);

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   // Every digit slot opens with BLANK unless blanking is disabled.
   localparam state_t ST_FIRST = state_t'((BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [CNT_W-1:0]        r_cnt;
   logic [CNT_W-1:0]        w_cnt_nxt;
   logic [IDX_W-1:0]        r_idx;
   logic [IDX_W-1:0]        w_idx_nxt;
   // Low through reset; keeps outputs dark and the scan parked until the
   // first edge after reset release, which starts the first frame.
   logic                    r_run;

   logic [4*NUM_DIGITS-1:0] r_shadow_data;
   logic [NUM_DIGITS-1:0]   r_shadow_dp;
   logic [NUM_DIGITS-1:0]   r_shadow_mask;
   logic                    r_pending;
   logic [4*NUM_DIGITS-1:0] r_disp_data;
   logic [NUM_DIGITS-1:0]   r_disp_dp;
   logic [NUM_DIGITS-1:0]   r_disp_mask;

   logic                    w_frame_start;
   logic                    w_commit;
   logic [4*NUM_DIGITS-1:0] w_cur_data;
   logic [NUM_DIGITS-1:0]   w_cur_dp;
   logic [NUM_DIGITS-1:0]   w_cur_mask;
   logic [3:0]              w_nibble;
   logic [6:0]              w_seg_dec;
   logic                    w_lit;

   assign w_frame_start = r_run && (r_idx == '0) && (r_cnt == '0) && (r_state == ST_FIRST);
   assign w_commit      = w_frame_start && r_pending;

   // The commit lands on the edge that ends the frame_start cycle; when that
   // cycle is already lit (no blanking) it shows the shadow directly so the
   // whole frame carries the new value.
   assign w_cur_data = w_commit ? r_shadow_data : r_disp_data;
   assign w_cur_dp   = w_commit ? r_shadow_dp   : r_disp_dp;
   assign w_cur_mask = w_commit ? r_shadow_mask : r_disp_mask;
   assign w_nibble   = w_cur_data[{r_idx, 2'b00} +: 4];
   assign w_lit      = r_run && (r_state == ST_SHOW) && !w_cur_mask[r_idx];

   seg7_hex_decoder u_dec (
      .i_nibble (w_nibble),
      .o_seg    (w_seg_dec)
   );

   // Scan state register: FSM, per-state cycle counter and digit index.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_FIRST;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_run   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_run   <= 1'b1;
      end
   end

   // Next-state logic: BLANK for BLANK_CYCLES, SHOW for DWELL_CYCLES, advance digit.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      if (r_run) begin
         case (r_state)
            ST_BLANK: begin
               if (r_cnt == BLANK_LAST) begin
                  w_state_nxt = ST_SHOW;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt   = r_cnt + CNT_W'(1);
               end
            end
            ST_SHOW: begin
               if (r_cnt == DWELL_LAST) begin
                  w_state_nxt = ST_FIRST;
                  w_cnt_nxt   = '0;
                  w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
               end else begin
                  w_cnt_nxt   = r_cnt + CNT_W'(1);
               end
            end
            default: begin
               w_state_nxt = ST_FIRST;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
            end
         endcase
      end
   end

   // Shadow capture on load and frame-boundary commit into the display register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shadow_data <= '0;
         r_shadow_dp   <= '0;
         r_shadow_mask <= '0;
         r_pending     <= 1'b0;
         r_disp_data   <= '0;
         r_disp_dp     <= '0;
         r_disp_mask   <= '0;
      end else begin
         if (load) begin
            r_shadow_data <= data_in;
            r_shadow_dp   <= dp_in;
            r_shadow_mask <= mask_in;
         end
         if (w_commit) begin
            r_disp_data <= r_shadow_data;
            r_disp_dp   <= r_shadow_dp;
            r_disp_mask <= r_shadow_mask;
         end
         // A load coinciding with the commit leaves fresh data still pending.
         if (load) begin
            r_pending <= 1'b1;
         end else if (w_commit) begin
            r_pending <= 1'b0;
         end
      end
   end

   // Output drive from registered state only; dark unless a digit is lit.
   always_comb begin
      anode = '1;
      seg   = SEG_OFF;
      dp    = DP_OFF;
      if (w_lit) begin
         anode = ~(NUM_DIGITS'(1) << r_idx);
         seg   = w_seg_dec;
         dp    = ~w_cur_dp[r_idx];
      end
   end

   assign pending     = r_pending;
   assign frame_start = w_frame_start;

endmodule
